mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 116 +++++++++++
 rtl/mc_decode.sv | 41 ++++
 rtl/mc_ctrl.sv | 157 +++++++++++++++
 tb/tb_mc_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller and its datapath:
// FSM state encoding, next-PC codes, datapath select codes, opcode/funct
// values and the one-hot instruction class vector.
package mc_ctrl_pkg;

    // Controller states; encodings 5-7 are unused and recover to FETCH.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Next-PC unit operation codes.
    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_JAL = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    // Register-file destination select.
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_DM  = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    // Immediate extension mode.
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    // Opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // One-hot instruction class bit positions.
    localparam int CLS_NOP  = 0;
    localparam int CLS_ADDU = 1;
    localparam int CLS_SUBU = 2;
    localparam int CLS_JR   = 3;
    localparam int CLS_ORI  = 4;
    localparam int CLS_LUI  = 5;
    localparam int CLS_LW   = 6;
    localparam int CLS_SW   = 7;
    localparam int CLS_BEQ  = 8;
    localparam int CLS_JAL  = 9;
    localparam int CLS_W    = 10;

    typedef logic [CLS_W-1:0] cls_t;

    // Datapath selects that stay fixed for the whole execution of one class.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       ext_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } dp_sel_t;

    // Map an instruction class to its datapath selects; jr and NOP use none.
    function automatic dp_sel_t class_sel(input cls_t cls);
        dp_sel_t sel;
        sel.alu_op     = ALU_ADD;
        sel.alu_src    = 1'b0;
        sel.ext_op     = EXT_ZERO;
        sel.reg_dst    = RD_RT;
        sel.mem_to_reg = MTR_ALU;
        if (cls[CLS_ADDU]) begin
            sel.reg_dst = RD_RD;
        end else if (cls[CLS_SUBU]) begin
            sel.reg_dst = RD_RD;
            sel.alu_op  = ALU_SUB;
        end else if (cls[CLS_ORI]) begin
            sel.alu_op  = ALU_OR;
            sel.alu_src = 1'b1;
        end else if (cls[CLS_LUI]) begin
            sel.alu_op  = ALU_LUI;
            sel.alu_src = 1'b1;
        end else if (cls[CLS_LW]) begin
            sel.alu_src    = 1'b1;
            sel.ext_op     = EXT_SIGN;
            sel.mem_to_reg = MTR_DM;
        end else if (cls[CLS_SW]) begin
            sel.alu_src = 1'b1;
            sel.ext_op  = EXT_SIGN;
        end else if (cls[CLS_BEQ]) begin
            sel.alu_op = ALU_SUB;
        end else if (cls[CLS_JAL]) begin
            sel.reg_dst    = RD_RA;
            sel.mem_to_reg = MTR_PC4;
        end else begin
            sel.alu_op = ALU_ADD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR contents -> one-hot class.
// Anything not explicitly recognised (including the all-zero word) is NOP.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [19:0] field_unused;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    // Register and immediate fields do not affect sequencing.
    assign field_unused = instr[25:6];

    // Classify on opcode, and on funct for R-type words.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: cls[CLS_SUBU] = 1'b1;
                    FN_JR:   cls[CLS_JR]   = 1'b1;
                    default: cls[CLS_NOP]  = 1'b1;
                endcase
            end
            OP_ORI:  cls[CLS_ORI] = 1'b1;
            OP_LUI:  cls[CLS_LUI] = 1'b1;
            OP_LW:   cls[CLS_LW]  = 1'b1;
            OP_SW:   cls[CLS_SW]  = 1'b1;
            OP_BEQ:  cls[CLS_BEQ] = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls[CLS_NOP] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXE/MEM/WB sequencer
// plus a retired-instruction counter. Control outputs are combinational
// from the current state and IR; PCWr fires once, in each instruction's
// last cycle, so the next-PC unit still sees the executing PC.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        IRWr,
    output logic        PCWr,
    output logic [2:0]  NPCOp,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [2:0]  ALUOp,
    output logic        ExtOp,
    output logic        MemWr,
    output logic [1:0]  MemtoReg,
    output logic        instr_done,
    output logic [2:0]  state,
    output logic [31:0] icount
);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] icount_r;
    cls_t        cls_s;
    dp_sel_t     sel_s;
    logic        ir_wr_s;
    logic        pc_wr_s;
    logic [2:0]  npc_op_s;
    logic        reg_wr_s;
    logic        mem_wr_s;
    logic        zero_unused;

    // The equality flag feeds the next-PC unit directly, not the sequencer.
    assign zero_unused = zero;

    mc_decode u_decode (
        .instr (instr),
        .cls   (cls_s)
    );

    // Next-state and control decode; selects are class-fixed from EXE on.
    always_comb begin
        next_state_s = ST_FETCH;
        ir_wr_s      = 1'b0;
        pc_wr_s      = 1'b0;
        npc_op_s     = NPC_PC4;
        reg_wr_s     = 1'b0;
        mem_wr_s     = 1'b0;
        sel_s        = '0;
        case (state_r)
            ST_FETCH: begin
                ir_wr_s      = 1'b1;
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls_s[CLS_JAL]) begin
                    sel_s        = class_sel(cls_s);
                    pc_wr_s      = 1'b1;
                    npc_op_s     = NPC_JAL;
                    reg_wr_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else if (cls_s[CLS_JR]) begin
                    pc_wr_s      = 1'b1;
                    npc_op_s     = NPC_JR;
                    next_state_s = ST_FETCH;
                end else if (cls_s[CLS_NOP]) begin
                    pc_wr_s      = 1'b1;
                    npc_op_s     = NPC_PC4;
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_EXE;
                end
            end
            ST_EXE: begin
                sel_s = class_sel(cls_s);
                if (cls_s[CLS_BEQ]) begin
                    pc_wr_s      = 1'b1;
                    npc_op_s     = NPC_BEQ;
                    next_state_s = ST_FETCH;
                end else if (cls_s[CLS_LW] | cls_s[CLS_SW]) begin
                    next_state_s = ST_MEM;
                end else if (cls_s[CLS_ADDU] | cls_s[CLS_SUBU] |
                             cls_s[CLS_ORI]  | cls_s[CLS_LUI]) begin
                    next_state_s = ST_WB;
                end else begin
                    // Class cannot reach EXE while IR is stable; recover quietly.
                    next_state_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                sel_s = class_sel(cls_s);
                if (cls_s[CLS_SW]) begin
                    mem_wr_s     = 1'b1;
                    pc_wr_s      = 1'b1;
                    npc_op_s     = NPC_PC4;
                    next_state_s = ST_FETCH;
                end else if (cls_s[CLS_LW]) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB: begin
                sel_s        = class_sel(cls_s);
                reg_wr_s     = 1'b1;
                pc_wr_s      = 1'b1;
                npc_op_s     = NPC_PC4;
                next_state_s = ST_FETCH;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, stepping on each PC update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            icount_r <= 32'd0;
        end else if (pc_wr_s) begin
            icount_r <= icount_r + 32'd1;
        end else begin
            icount_r <= icount_r;
        end
    end

    // Write enables are suppressed for as long as reset is held low.
    assign IRWr       = reset & ir_wr_s;
    assign PCWr       = reset & pc_wr_s;
    assign RegWr      = reset & reg_wr_s;
    assign MemWr      = reset & mem_wr_s;
    assign instr_done = reset & pc_wr_s;
    assign NPCOp      = npc_op_s;
    assign RegDst     = sel_s.reg_dst;
    assign ALUSrc     = sel_s.alu_src;
    assign ALUOp      = sel_s.alu_op;
    assign ExtOp      = sel_s.ext_op;
    assign MemtoReg   = sel_s.mem_to_reg;
    assign state      = state_r;
    assign icount     = icount_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed sequences plus randomized
// instructions and resets, compared every cycle against a step-indexed
// behavioural model, with literal pins on selected cycles.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        IRWr, PCWr, RegWr, ALUSrc, ExtOp, MemWr, instr_done;
    logic [2:0]  NPCOp, ALUOp, state;
    logic [1:0]  RegDst, MemtoReg;
    logic [31:0] icount;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_instr = 32'd0;
    int          kstep = 0;
    logic [31:0] mcount = 32'd0;
    int          pin = 0;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          seq_cycles = 0;

    localparam int C_NOP = 0, C_ADDU = 1, C_SUBU = 2, C_JR = 3, C_ORI = 4;
    localparam int C_LUI = 5, C_LW = 6, C_SW = 7, C_BEQ = 8, C_JAL = 9;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .IRWr       (IRWr),
        .PCWr       (PCWr),
        .NPCOp      (NPCOp),
        .RegWr      (RegWr),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
        .ExtOp      (ExtOp),
        .MemWr      (MemWr),
        .MemtoReg   (MemtoReg),
        .instr_done (instr_done),
        .state      (state),
        .icount     (icount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int m_class(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h21) return C_ADDU;
            if (fn == 6'h23) return C_SUBU;
            if (fn == 6'h08) return C_JR;
            return C_NOP;
        end
        if (op == 6'h0D) return C_ORI;
        if (op == 6'h0F) return C_LUI;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h03) return C_JAL;
        return C_NOP;
    endfunction

    function automatic int m_latency(input int c);
        if (c == C_NOP || c == C_JAL || c == C_JR) return 2;
        if (c == C_BEQ) return 3;
        if (c == C_LW) return 5;
        return 4;
    endfunction

    // Expected outputs at cycle k of instruction w:
    // {IRWr,PCWr,NPCOp,RegWr,RegDst,ALUSrc,ALUOp,ExtOp,MemWr,MemtoReg,instr_done,state}
    function automatic logic [19:0] m_out(input logic [31:0] w, input int k, input logic rst_n);
        int         c;
        bit         fin;
        logic       irwr, pcwr, regwr, memwr, src, ext;
        logic [2:0] npc, st, alu;
        logic [1:0] dst, mtr;
        c     = m_class(w);
        fin   = (k == m_latency(c) - 1);
        irwr  = (k == 0);
        pcwr  = fin;
        regwr = fin && (c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_JAL});
        memwr = fin && (c == C_SW);
        npc   = 3'b000;
        if (fin && c == C_JAL) npc = 3'b010;
        if (fin && c == C_JR)  npc = 3'b011;
        if (fin && c == C_BEQ) npc = 3'b001;
        if (k <= 2) st = 3'(k);
        else if (k == 3 && (c == C_LW || c == C_SW)) st = 3'd3;
        else st = 3'd4;
        alu = 3'b000; src = 1'b0; ext = 1'b0; dst = 2'b00; mtr = 2'b00;
        if (k >= 2 || (c == C_JAL && k == 1)) begin
            case (c)
                C_ADDU: dst = 2'b01;
                C_SUBU: begin dst = 2'b01; alu = 3'b001; end
                C_ORI:  begin alu = 3'b010; src = 1'b1; end
                C_LUI:  begin alu = 3'b011; src = 1'b1; end
                C_LW:   begin src = 1'b1; ext = 1'b1; mtr = 2'b01; end
                C_SW:   begin src = 1'b1; ext = 1'b1; end
                C_BEQ:  alu = 3'b001;
                C_JAL:  begin dst = 2'b10; mtr = 2'b10; end
                default: alu = 3'b000;
            endcase
        end
        if (!rst_n) begin
            irwr = 1'b0; pcwr = 1'b0; regwr = 1'b0; memwr = 1'b0;
        end
        return {irwr, pcwr, npc, regwr, dst, src, alu, ext, memwr, mtr, pcwr, st};
    endfunction

    task automatic pin_check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Compare process: full output vector and icount every cycle, plus pins.
    always @(negedge clk) begin
        logic [19:0] got;
        logic [19:0] want;
        if (chk_en) begin
            got  = {IRWr, PCWr, NPCOp, RegWr, RegDst, ALUSrc, ALUOp, ExtOp,
                    MemWr, MemtoReg, instr_done, state};
            want = m_out(cur_instr, kstep, reset);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t instr=%h step=%0d: got %b expected %b",
                         $time, cur_instr, kstep, got, want);
            end
            checks++;
            if (icount !== mcount) begin
                errors++;
                $display("FAIL icount t=%0t: got %h expected %h", $time, icount, mcount);
            end
            case (pin)
                1: pin_check("reset_state", 64'({state, icount, IRWr, PCWr, instr_done}),
                             64'({3'd0, 32'd0, 3'b000}));
                2: pin_check("lw_wb", 64'({RegWr, RegDst, MemtoReg, ALUSrc, ExtOp, NPCOp, PCWr, state}),
                             64'({1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 3'b000, 1'b1, 3'd4}));
                3: pin_check("jal_decode", 64'({PCWr, NPCOp, RegWr, RegDst, MemtoReg, state}),
                             64'({1'b1, 3'b010, 1'b1, 2'b10, 2'b10, 3'd1}));
                4: pin_check("nop_decode", 64'({PCWr, NPCOp, RegWr, MemWr, state}),
                             64'({1'b1, 3'b000, 1'b0, 1'b0, 3'd1}));
                5: begin
                    pin_check("seq_icount", 64'(icount), 64'd7);
                    pin_check("seq_cycles", 64'(seq_cycles), 64'd24);
                end
                6: pin_check("icount_wrap", 64'(icount), 64'd0);
                7: pin_check("abort_state", 64'({state, icount, MemWr, RegWr, PCWr}),
                             64'({3'd0, 32'd0, 3'b000}));
                8: pin_check("abort_in_mem", 64'({state, MemWr, RegWr, PCWr}),
                             64'({3'd3, 3'b000}));
                default: ;
            endcase
        end
    end

    // Run one instruction through its cycles; optionally pin a step, or
    // assert reset for two cycles starting at step abort_at.
    task automatic run_instr(input logic [31:0] w, input logic z, input int pin_step,
                             input int pin_id, input int abort_at);
        int lat;
        instr     = w;
        zero      = z;
        cur_instr = w;
        lat       = m_latency(m_class(w));
        for (int k = 0; k < lat; k++) begin
            kstep = k;
            pin   = (k == pin_step) ? pin_id : 0;
            if (k == abort_at) reset = 1'b0;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                kstep  = 0;
                mcount = 32'd0;
                pin    = 7;
                @(posedge clk);
                #1;
                reset = 1'b1;
                pin   = 0;
                return;
            end
            if (k == lat - 1) mcount = mcount + 32'd1;
        end
        kstep = 0;
        pin   = 0;
    endtask

    initial begin
        int start;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        pin    = 1;
        @(posedge clk);
        #1;
        pin   = 0;
        reset = 1'b1;

        // addu, ori, lw, sw, beq, jal, jr
        start = cyc;
        run_instr(32'h0022_1821, 1'b0, -1, 0, -1);
        run_instr(32'h3404_1234, 1'b0, -1, 0, -1);
        run_instr(32'h8C88_0004, 1'b0,  4, 2, -1);
        run_instr(32'hAC88_0004, 1'b0, -1, 0, -1);
        run_instr(32'h1022_0003, 1'b0, -1, 0, -1);
        run_instr(32'h0C00_0C00, 1'b0,  1, 3, -1);
        run_instr(32'h03E0_0008, 1'b0, -1, 0, -1);
        seq_cycles = cyc - start;

        // NOP words
        run_instr(32'h0000_0000, 1'b0, 0, 5, -1);
        run_instr(32'h0000_0000, 1'b0, 1, 4, -1);
        run_instr(32'hFC00_0000, 1'b1, 1, 4, -1);

        // Reset held two cycles while lw sits in MEM
        run_instr(32'h8C88_0004, 1'b0, 3, 8, 3);

        // Counter wrap from all-ones
        force dut.icount_r = 32'hFFFF_FFFF;
        #1;
        release dut.icount_r;
        mcount = 32'hFFFF_FFFF;
        run_instr(32'h0000_0000, 1'b0, -1, 0, -1);
        run_instr(32'h0000_0000, 1'b0,  0, 6, -1);

        // Randomized instruction stream with occasional resets
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            int          kind;
            int          ab;
            w    = $urandom;
            kind = $urandom_range(10, 0);
            case (kind)
                0: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
                1: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
                2: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
                3: w[31:26] = 6'h0D;
                4: w[31:26] = 6'h0F;
                5: w[31:26] = 6'h23;
                6: w[31:26] = 6'h2B;
                7: w[31:26] = 6'h04;
                8: w[31:26] = 6'h03;
                9: w = 32'd0;
                default: w = $urandom;
            endcase
            ab = -1;
            if ($urandom_range(9, 0) == 0) begin
                ab = $urandom_range(m_latency(m_class(w)) - 1, 0);
            end
            run_instr(w, 1'($urandom), -1, 0, ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
